// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset PC and fetch FSM state encodings for the instruction-fetch unit.
// States are plain typed constants so legacy code comparing raw 3-bit values keeps working.
package ifu_fetch_pkg;

  localparam int unsigned REG_WIDTH  = 64;
  localparam int unsigned INST_WIDTH = 32;

  localparam logic [REG_WIDTH-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef logic [2:0] ifu_state_e;

  localparam ifu_state_e IDLE = 3'd0;
  localparam ifu_state_e REQ  = 3'd1;
  localparam ifu_state_e WAIT = 3'd2;
  localparam ifu_state_e HOLD = 3'd3;
  localparam ifu_state_e DROP = 3'd4;

endpackage

// File: rtl/ifu_inst_sel.sv
// Picks the 32-bit instruction out of an aligned doubleword; sel is pc[2]
// (little-endian, so the lower address lives in the low half).
module ifu_inst_sel #(
  parameter int unsigned INST_W = 32
) (
  input  logic [2*INST_W-1:0] dword,
  input  logic                sel,
  output logic [INST_W-1:0]   word
);

  always_comb begin
    word = sel ? dword[2*INST_W-1:INST_W] : dword[INST_W-1:0];
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch initiator: owns the fetch PC, issues one doubleword read at a time
// and hands the selected word to decode; redirects can abandon work in any state.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = REG_WIDTH,
  parameter int unsigned          INST_W   = INST_WIDTH,
  parameter logic [ADDR_W-1:0]    RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_rsp_valid,
  input  logic [2*INST_W-1:0] mem_rsp_data,
  output logic                mem_rsp_ready,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [ADDR_W-1:0]   inst_pc,
  output logic [INST_W-1:0]   inst
);

  ifu_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   inst_pc_q;
  logic [INST_W-1:0]   inst_q;
  logic [INST_W-1:0]   sel_word;
  logic                capture;

  ifu_inst_sel #(
    .INST_W (INST_W)
  ) u_inst_sel (
    .dword (mem_rsp_data),
    .sel   (pc_q[2]),
    .word  (sel_word)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~ADDR_W'(3);
      // An accepted request with no consumed response leaves a stale reply to drain in DROP.
      case (state_q)
        REQ:     state_d = mem_req_ready ? DROP : REQ;
        WAIT:    state_d = mem_rsp_valid ? REQ : DROP;
        DROP:    state_d = mem_rsp_valid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (mem_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            pc_d    = pc_q + ADDR_W'(4);
            state_d = REQ;
          end
        end
        DROP: begin
          if (mem_rsp_valid) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (capture) begin
        inst_q    <= sel_word;
        inst_pc_q <= pc_q;
      end
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = {pc_q[ADDR_W-1:3], 3'b000};
  assign mem_rsp_ready = (state_q == WAIT) || (state_q == DROP);
  assign inst_valid    = (state_q == HOLD);
  assign inst_pc       = inst_pc_q;
  assign inst          = inst_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: acts as instruction memory and decode, with a reference model
// tracking the architectural PC and the outstanding memory request.
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_data = '0;
  logic        mem_rsp_ready;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] inst_pc;
  logic [31:0] inst;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // reference model state
  logic [63:0] exp_pc;
  bit          pend_valid;
  logic [63:0] pend_addr;
  int          pend_cnt;
  int unsigned handshakes;
  logic [63:0] last_pc;
  logic [31:0] last_inst;
  logic [63:0] acc_q[$];
  logic [63:0] hs_pc_q[$];
  logic [31:0] hs_inst_q[$];
  int unsigned idle_cycles;
  bit          stall_req;
  logic [63:0] stall_addr;
  bit          stall_inst;

  // stimulus knobs
  int          rdy_pct;
  int          dec_pct;
  int          fix_lat;
  int          redir_pct;
  bit          force_redir;
  logic [63:0] redir_target;

  ifu_fetch #(
    .ADDR_W   (64),
    .INST_W   (32),
    .RESET_PC (64'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_ready  (mem_rsp_ready),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst           (inst)
  );

  always #5 clk = ~clk;

  // Memory contents as a word-addressed image; the two reset-vector words are fixed.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0000_0013;
    if (a == 64'h8000_0004) return 32'h0010_0093;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [63:0] dword_at(input logic [63:0] a);
    return {word_at(a + 64'd4), word_at(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc      = RST_PC;
    pend_valid  = 0;
    pend_cnt    = 0;
    stall_req   = 0;
    stall_inst  = 0;
    idle_cycles = 0;
    force_redir = 0;
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic step();
    logic        s_req_v, s_rsp_r, s_inst_v, redir, hs;
    logic [63:0] s_addr, s_ipc, tgt;
    logic [31:0] s_inst;
    s_req_v  = mem_req_valid;
    s_rsp_r  = mem_rsp_ready;
    s_inst_v = inst_valid;
    s_addr   = mem_req_addr;
    s_ipc    = inst_pc;
    s_inst   = inst;

    chk("rsp_ready", s_rsp_r, pend_valid);
    if (pend_valid) begin
      chk("req_while_outstanding", s_req_v, 0);
      chk("inst_while_outstanding", s_inst_v, 0);
    end
    if (s_req_v) chk("req_addr", s_addr, {exp_pc[63:3], 3'b000});
    if (s_inst_v) begin
      chk("inst_pc", s_ipc, exp_pc);
      chk("inst", s_inst, word_at(exp_pc));
      chk("req_in_hold", s_req_v, 0);
    end
    if (stall_req) begin
      chk("req_held_valid", s_req_v, 1);
      chk("req_held_addr", s_addr, stall_addr);
    end
    if (stall_inst) chk("inst_held_valid", s_inst_v, 1);
    if (idle_cycles > 200) begin
      chk("progress_timeout", idle_cycles, 0);
      idle_cycles = 0;
    end

    mem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    mem_rsp_valid = pend_valid && (pend_cnt == 0);
    mem_rsp_data  = mem_rsp_valid ? dword_at(pend_addr) : {$urandom, $urandom};
    inst_ready    = ($urandom_range(0, 99) < dec_pct);
    redir = force_redir || ($urandom_range(0, 99) < redir_pct);
    if (force_redir) tgt = redir_target;
    else if ($urandom_range(0, 3) == 0) tgt = {$urandom, $urandom};
    else tgt = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFF)};
    redirect_valid = redir;
    redirect_pc    = redir ? tgt : {$urandom, $urandom};
    force_redir    = 0;

    @(posedge clk);

    hs = s_inst_v && inst_ready && !redir;
    if (redir) exp_pc = tgt & ~64'd3;
    else if (hs) begin
      handshakes++;
      last_pc   = s_ipc;
      last_inst = s_inst;
      hs_pc_q.push_back(s_ipc);
      hs_inst_q.push_back(s_inst);
      exp_pc = exp_pc + 64'd4;
    end
    if (mem_rsp_valid && s_rsp_r) pend_valid = 0;
    else if (pend_valid && pend_cnt > 0) pend_cnt--;
    if (s_req_v && mem_req_ready) begin
      pend_valid = 1;
      pend_addr  = s_addr;
      pend_cnt   = ((fix_lat > 0) ? fix_lat : int'($urandom_range(1, 4))) - 1;
      acc_q.push_back(s_addr);
    end
    stall_req   = s_req_v && !mem_req_ready && !redir;
    stall_addr  = s_addr;
    stall_inst  = s_inst_v && !inst_ready && !redir;
    idle_cycles = (hs || redir) ? 0 : idle_cycles + 1;
    @(negedge clk);
  endtask

  initial begin
    int unsigned hs0;
    int unsigned idx;
    logic [63:0] p;
    logic [63:0] np;
    logic [63:0] ad;

    handshakes = 0;
    rdy_pct = 100; dec_pct = 100; fix_lat = 1; redir_pct = 0;
    redir_target = '0;
    last_pc = '0; last_inst = '0;
    model_reset();

    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_rsp_ready", mem_rsp_ready, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;
    chk("idle_req_valid", mem_req_valid, 0);

    // back-to-back fetches from the reset doubleword, 1-cycle memory
    for (int n = 0; n < 30 && handshakes < 2; n++) step();
    chk("p1_handshakes", handshakes, 2);
    chk("p1_acc0", acc_q[0], 64'h8000_0000);
    chk("p1_acc1", acc_q[1], 64'h8000_0000);
    chk("p1_pc0", hs_pc_q[0], 64'h8000_0000);
    chk("p1_inst0", hs_inst_q[0], 32'h0000_0013);
    chk("p1_pc1", hs_pc_q[1], 64'h8000_0004);
    chk("p1_inst1", hs_inst_q[1], 32'h0010_0093);

    // decode stalls for 5 cycles in HOLD
    dec_pct = 0;
    for (int n = 0; n < 20 && !inst_valid; n++) step();
    chk("p2_reach_hold", inst_valid, 1);
    p = exp_pc;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("p2_still_valid", inst_valid, 1);
      chk("p2_no_req", mem_req_valid, 0);
      chk("p2_inst_pc", inst_pc, 64'h8000_0008);
    end
    dec_pct = 100;
    step();
    for (int n = 0; n < 10 && !mem_req_valid; n++) step();
    np = p + 64'd4;
    chk("p2_next_req", mem_req_valid, 1);
    chk("p2_next_addr", mem_req_addr, {np[63:3], 3'b000});

    // memory refuses the request for 3 cycles
    rdy_pct = 0;
    for (int n = 0; n < 20 && !mem_req_valid; n++) step();
    ad = mem_req_addr;
    chk("p3_addr", ad, {exp_pc[63:3], 3'b000});
    for (int n = 0; n < 3; n++) begin
      step();
      chk("p3_valid_held", mem_req_valid, 1);
      chk("p3_addr_held", mem_req_addr, {exp_pc[63:3], 3'b000});
    end
    rdy_pct = 100;

    // redirect while waiting on a 4-cycle response
    fix_lat = 4;
    for (int n = 0; n < 20 && !pend_valid; n++) step();
    chk("p4_in_wait", mem_rsp_ready, 1);
    force_redir = 1;
    redir_target = 64'h8000_0103;
    step();
    idx = acc_q.size();
    hs0 = handshakes;
    chk("p4_no_inst", inst_valid, 0);
    for (int n = 0; n < 40 && handshakes == hs0; n++) step();
    chk("p4_addr", acc_q[idx], 64'h8000_0100);
    chk("p4_pc", last_pc, 64'h8000_0100);
    chk("p4_inst", last_inst, word_at(64'h8000_0100));
    fix_lat = 1;

    // redirect in HOLD with decode ready in the same cycle
    dec_pct = 0;
    for (int n = 0; n < 20 && !inst_valid; n++) step();
    chk("p5_reach_hold", inst_valid, 1);
    dec_pct = 100;
    force_redir = 1;
    redir_target = 64'h8000_2000;
    hs0 = handshakes;
    step();
    chk("p5_inst_dropped", inst_valid, 0);
    chk("p5_req_valid", mem_req_valid, 1);
    chk("p5_req_addr", mem_req_addr, 64'h8000_2000);
    for (int n = 0; n < 20 && handshakes == hs0; n++) step();
    chk("p5_pc", last_pc, 64'h8000_2000);

    // PC wraps past the top of the address space
    force_redir = 1;
    redir_target = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    idx = acc_q.size();
    hs0 = handshakes;
    for (int n = 0; n < 40 && handshakes < hs0 + 2; n++) step();
    chk("p6_addr_top", acc_q[idx], 64'hFFFF_FFFF_FFFF_FFF8);
    chk("p6_addr_wrap", acc_q[idx + 1], 64'h0);
    chk("p6_pc_top", hs_pc_q[hs0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("p6_pc_wrap", hs_pc_q[hs0 + 1], 64'h0);

    // randomized traffic with random redirects
    rdy_pct = 70; dec_pct = 70; fix_lat = 0; redir_pct = 6;
    hs0 = handshakes;
    for (int n = 0; n < 3000; n++) step();
    redir_pct = 0;
    chk("p7_progress", (handshakes > hs0 + 100), 1);

    // asynchronous reset while a fetch is outstanding
    rdy_pct = 100; dec_pct = 100; fix_lat = 3;
    for (int n = 0; n < 20 && !pend_valid; n++) step();
    chk("p8_in_wait", mem_rsp_ready, 1);
    mem_req_ready = 0; mem_rsp_valid = 0; inst_ready = 0; redirect_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("p8_req_valid", mem_req_valid, 0);
    chk("p8_rsp_ready", mem_rsp_ready, 0);
    chk("p8_inst_valid", inst_valid, 0);
    chk("p8_inst", inst, 0);
    chk("p8_inst_pc", inst_pc, RST_PC);
    model_reset();
    fix_lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    hs0 = handshakes;
    for (int n = 0; n < 30 && handshakes == hs0; n++) step();
    chk("p8_pc", last_pc, RST_PC);
    chk("p8_inst_after", last_inst, 32'h0000_0013);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch initiator: the requesting end of the instruction-memory interface.
- Holds the architectural fetch PC and issues 8-byte-aligned read requests to the instruction memory over a valid/ready request channel and a valid/ready response channel.
- Extracts the 32-bit instruction word selected by pc[2] and presents it to decode with a valid/ready handshake.
- Supports redirects (branch/jump/trap) at any time, discarding in-flight or held fetches.

Parameters:
- RESET_PC, 64'h8000_0000, fetch PC loaded on reset.
- ADDR_W, `RegWidth (64), PC and address width.
- INST_W, `InstWidth (32), instruction width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- redirect_valid  in  1  replace fetch PC this cycle.
- redirect_pc  in  ADDR_W  new PC; bits [1:0] ignored (forced 0).
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  {pc[63:3],3'b000}.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  64  aligned doubleword.
- mem_rsp_ready  out  1  fetch accepts response.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst_pc  out  ADDR_W  PC of presented instruction.
- inst  out  INST_W  instruction word.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - pc=RESET_PC, state=IDLE.
  - mem_req_valid=0, mem_rsp_ready=0, inst_valid=0, inst=0, inst_pc=RESET_PC.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: mem_req_valid=1. On mem_req_ready, go to WAIT.
  - WAIT: mem_rsp_ready=1. On mem_rsp_valid, capture inst=pc[2] ? data[63:32] : data[31:0], set inst_pc=pc, go to HOLD.
  - HOLD: inst_valid=1. inst and inst_pc stay stable until inst_valid&&inst_ready. On handshake, pc<=pc+4 and go to REQ.
  - DROP: mem_rsp_ready=1, inst_valid=0. On mem_rsp_valid, discard the data and go to REQ.
- Request channel:
  - mem_req_addr is stable while mem_req_valid=1 and not accepted.
  - At most one outstanding request.
- Response latency: a response may arrive in the cycle after acceptance or later. The minimum is 1 cycle, so REQ→WAIT→HOLD takes ≥2 cycles per instruction; no combinational path from request to response.
- Redirect (highest priority; pc<=redirect_pc&~3 in all cases):
  - IDLE/REQ without acceptance: go to REQ. The address changes next cycle, which is legal because the current request is abandoned.
  - REQ with mem_req_ready the same cycle: the request is considered issued; go to DROP.
  - WAIT without mem_rsp_valid: go to DROP.
  - WAIT with mem_rsp_valid the same cycle: the response is consumed and discarded; go to REQ.
  - HOLD: the held instruction is discarded, inst_valid=0 next cycle; go to REQ. This applies even if inst_ready=1 the same cycle: the redirect wins and pc is not incremented.
  - DROP: stay in DROP until the stale response arrives. A response arriving the same cycle as the redirect is discarded and the state goes to REQ.
- Width rules:
  - pc+4 wraps modulo 2^64, no fault.
  - pc[1:0] is always 0.
- Asynchronous reset mid-transaction: returns to IDLE immediately. Memory-side cleanup is the memory's responsibility.
- Unused upper bits: none. The full doubleword is consumed via pc[2].

Decomposition:
- Shared package/defines: `RegWidth, `InstWidth (existing), RESET_PC constant, ifu_state_e enum {IDLE, REQ, WAIT, HOLD, DROP}.
- Sub-module: ifu_inst_sel (combinational doubleword→word select by pc[2]). The rest stays in one module.

Test Plan:
- Reset then a memory with 1-cycle response, data 64'h00100093_00000013: fetches 0x8000_0000 → inst 0x00000013, then 0x8000_0004 → 0x00100093 (same doubleword address 0x8000_0000 issued twice).
- Decode holds inst_ready=0 for 5 cycles at HOLD: inst/inst_pc stable and no new mem_req_valid; after the ready pulse, the next request goes to addr pc+4.
- Memory holds mem_req_ready=0 for 3 cycles: mem_req_valid held high and mem_req_addr stable.
- Redirect to 0x8000_0103 while in WAIT with a 4-cycle response: the stale response is dropped, no inst_valid; the next request goes to addr 0x8000_0100, and inst_pc=0x8000_0100 selects the low word.
- Redirect in HOLD with inst_ready=1 in the same cycle: no handshake counted, pc=redirect target, and the next inst_pc equals the target.
- pc=64'hFFFF_FFFF_FFFF_FFFC, then accept: the next fetch addr wraps to 0x0.
